// File: rtl/ascii_digit_encoder.sv
// Purpose: scans a 16x8 register file and rewrites binary digit entries in place as ASCII characters,
//          then steps the entries across cur_char for the board display.
// Latency: 3 cycles per non-digit entry and 4 per converted entry, 1 cycle in DSTART, then DWELL*DEPTH display cycles.
// Backpressure: none. A run starts on go in IDLE, and HALT waits for go to drop before re-arming.
// Optional feature: define ENC_HEX_EN to also convert values 10-15 into 'A'-'F'.
module ascii_digit_encoder #(
  parameter int DEPTH     = 16,
  parameter int MAX_COUNT = 8,
  parameter int DWELL     = 10000
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       go,
  output logic [3:0] addr,
  input  logic [7:0] R_data,
  output logic [7:0] W_data,
  output logic       W_en,
  output logic [5:0] count,
  output logic [6:0] cur_char,
  output logic       done
);

  localparam int            KW        = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [3:0]    LAST_IDX  = 4'(DEPTH - 1);
  localparam logic [5:0]    CNT_LIMIT = 6'(MAX_COUNT);
  localparam logic [KW-1:0] K_LAST    = KW'(DWELL - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CHECK,
    S_WRITE,
    S_NEXT,
    S_DSTART,
    S_DISP,
    S_HALT
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    idx_q, idx_d;
  logic [7:0]    val_q, val_d;
  logic [7:0]    wdata_q, wdata_d;
  logic          wen_q, wen_d;
  logic [5:0]    cnt_q, cnt_d;
  logic [6:0]    char_q, char_d;
  logic          done_q, done_d;
  logic [KW-1:0] k_q, k_d;

  // Decide whether the fetched value gets converted and what it becomes.
  logic          conv;
  logic [7:0]    enc;

  // Classify the latched entry and form its ASCII replacement.
  always_comb begin
    conv = 1'b0;
    enc  = val_q;
`ifdef ENC_HEX_EN
    if (val_q <= 8'd9) begin
      conv = 1'b1;
      enc  = val_q + 8'd48;
    end else if (val_q <= 8'd15) begin
      conv = 1'b1;
      enc  = val_q + 8'd55;
    end
`else
    if (val_q <= 8'd9) begin
      conv = 1'b1;
      enc  = val_q + 8'd48;
    end
`endif
  end

  // Next-state logic. Output registers are loaded on the transition into a state,
  // so every output is a clean flop that reflects the current state.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    val_d   = val_q;
    wdata_d = wdata_q;
    wen_d   = 1'b0;
    cnt_d   = cnt_q;
    char_d  = char_q;
    done_d  = done_q;
    k_d     = k_q;
    case (state_q)
      S_IDLE: begin
        idx_d  = 4'd0;
        cnt_d  = 6'd0;
        done_d = 1'b0;
        if (go) begin
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        val_d   = R_data;
        char_d  = R_data[6:0];
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (conv) begin
          wen_d   = 1'b1;
          wdata_d = enc;
          state_d = S_WRITE;
        end else begin
          state_d = S_NEXT;
        end
      end
      S_WRITE: begin
        cnt_d   = cnt_q + 6'd1;
        state_d = S_NEXT;
      end
      S_NEXT: begin
        if (cnt_q == CNT_LIMIT || idx_q == LAST_IDX) begin
          state_d = S_DSTART;
        end else begin
          idx_d   = idx_q + 4'd1;
          state_d = S_FETCH;
        end
      end
      S_DSTART: begin
        idx_d   = 4'd0;
        k_d     = '0;
        done_d  = 1'b1;
        state_d = S_DISP;
      end
      S_DISP: begin
        done_d = 1'b1;
        char_d = R_data[6:0];
        if (k_q == K_LAST) begin
          k_d = '0;
          if (idx_q == LAST_IDX) begin
            state_d = S_HALT;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      S_HALT: begin
        done_d = 1'b1;
        // Require go to fall so one long go cannot retrigger a run.
        if (!go) begin
          state_d = S_IDLE;
          idx_d   = 4'd0;
          cnt_d   = 6'd0;
          done_d  = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers. Reset clears everything at once, so W_en drops mid-write.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= 4'd0;
      val_q   <= 8'd0;
      wdata_q <= 8'd0;
      wen_q   <= 1'b0;
      cnt_q   <= 6'd0;
      char_q  <= 7'd0;
      done_q  <= 1'b0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      val_q   <= val_d;
      wdata_q <= wdata_d;
      wen_q   <= wen_d;
      cnt_q   <= cnt_d;
      char_q  <= char_d;
      done_q  <= done_d;
      k_q     <= k_d;
    end
  end

  assign addr     = idx_q;
  assign W_data   = wdata_q;
  assign W_en     = wen_q;
  assign count    = cnt_q;
  assign cur_char = char_q;
  assign done     = done_q;

endmodule

// File: doc/ascii_digit_encoder.md
# ascii_digit_encoder

- Inverse of the ASCII-to-digit converter that sits on the same 16x8 register file.
- Scans the register file from address 0 and rewrites every binary digit entry (0–9) in place as its ASCII character (value + 48).
- Counts the conversions and stops early at a configurable limit.
- After the scan, steps through the file once at a human-visible rate on `cur_char` for the board display, then raises `done`.

## Interface
Parameters:
- `DEPTH`, 16: number of register-file entries scanned. The address is fixed at 4 bits, so `DEPTH` ≤ 16.
- `MAX_COUNT`, 8: the scan ends once this many entries have been converted.
- `DWELL`, 10000: clock cycles each entry is held on `cur_char` during display.

Ports:
- `Clk` input 1: the single clock. All state changes on its rising edge.
- `Rst_n` input 1: asynchronous, active-low reset.
- `go` input 1: start request, sampled in IDLE.
- `addr` output 4: shared read/write address to the register file.
- `R_data` input 8: register-file read data. Combinational read, valid in the same cycle as `addr`.
- `W_data` output 8: write data.
- `W_en` output 1: write strobe. The file writes `W_data` at `addr` on the next rising edge of `Clk`.
- `count` output 6: number of entries converted in the current run.
- `cur_char` output 7: character currently shown (low 7 bits of the fetched or displayed entry).
- `done` output 1: high during display and halt.

## Operation
- States: IDLE, FETCH, CHECK, WRITE, NEXT, DSTART, DISP, HALT. All outputs are registered (Moore).
- IDLE:
  - Drives `addr`=0, `count`=0, `W_en`=0, `done`=0.
  - If `go`=1, go to FETCH.
- FETCH:
  - Latch `R_data` into internal `val[7:0]`.
  - `cur_char` <= `R_data[6:0]`.
  - Go to CHECK.
- CHECK:
  - If `val` ≤ 9, go to WRITE; otherwise go to NEXT.
  - Entries already in ASCII, and all other values, are left untouched.
- WRITE:
  - `W_en`=1 for exactly this one cycle, with `W_data` = `val` + 48 (8-bit, no overflow possible) and `addr` = current index.
  - `count` increments by 1.
  - Go to NEXT.
- NEXT:
  - If `count` == `MAX_COUNT` or index == `DEPTH`-1, go to DSTART.
  - Otherwise increment the index and go to FETCH.
- DSTART:
  - Index <= 0; dwell counter `k` <= 0.
  - Go to DISP.
- DISP:
  - `done`=1.
  - `cur_char` <= `R_data[6:0]` at the current index.
  - `k` increments every cycle. When `k` reaches `DWELL`-1:
    - If index == `DEPTH`-1, go to HALT.
    - Otherwise increment the index, clear `k`, and stay in DISP.
- HALT:
  - `done`=1; `cur_char` holds its last value.
  - When `go`=0, return to IDLE, so a new run needs a fresh `go`.
- `count` holds its final value through DISP and HALT. It is cleared only in IDLE.

## Timing
- Reset values: state IDLE; `addr`=0, `W_data`=0, `W_en`=0, `count`=0, `cur_char`=0, `done`=0, `k`=0.
- Reset is asynchronous and applies mid-operation too: `W_en` drops immediately. A partially written entry cannot occur because each write is a single cycle.
- Start: `go` is sampled high in IDLE at edge N; FETCH of address 0 occurs in cycle N+1.
- Per-entry cost: 3 cycles for a non-digit (FETCH, CHECK, NEXT); 4 cycles for a digit (adds WRITE).
- Full scan of 16 non-digits: 48 cycles from the first FETCH to DSTART.
- Early stop:
  - When the 8th conversion's WRITE completes, NEXT goes to DSTART.
  - Entries beyond that point are not read or written.
- Display:
  - 1 cycle in DSTART, then `DWELL` × `DEPTH` cycles in DISP.
  - `done` rises on the first DISP cycle.
- `go` is ignored outside IDLE and HALT.
- `count` width is 6 bits and `MAX_COUNT` ≤ 16, so `count` never wraps.

## Configuration
- `ENC_HEX_EN`, defined: CHECK also accepts `val` 10–15 and writes `val` + 55 ('A'–'F'). These writes count toward `MAX_COUNT`.
- `ENC_HEX_EN`, undefined: only 0–9 are converted. Values 10–15 are left unchanged and are not counted.

## Test plan
- File = {0,1,…,9,'A'(65),0xFF,…}, `MAX_COUNT`=16, `go` pulse → entries 0–9 become 48–57, others unchanged, `count`=10, `done` rises after display.
- File = all 3 with `MAX_COUNT`=8 → entries 0–7 become 51, entries 8–15 remain 3, `count`=8, exactly 8 `W_en` pulses, each 1 cycle wide.
- File = all 'Z'(90) → no `W_en` pulses, `count`=0, 48 scan cycles before DSTART.
- `Rst_n` asserted low during the WRITE of entry 5 → all outputs return to reset values in the same cycle; after release with `go`, the scan restarts at address 0.
- `DWELL`=4, file entry i = 48+i → `cur_char` steps 48, 49, … every 4 cycles; HALT is reached after 64 DISP cycles; `go` low→high restarts the run.
- With `ENC_HEX_EN` defined, entry value 12 → written as 67 ('C') and `count` increments; with the macro undefined, the entry stays 12 and `count` is unaffected.
